// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with a manual select and an auto-scan mode.
// Optional channel mask port msk enabled by defining MUX_SCAN_MASK_EN.
module mux_scan #(
    parameter int unsigned W     = 1,
    parameter int unsigned N     = 8,
    parameter int unsigned SW    = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   d,
    input  logic [SW-1:0]    s,
    input  logic             ld,
    input  logic             mode,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]     msk,
`endif
    output logic [W-1:0]     out,
    output logic [SW-1:0]    ch,
    output logic             vld,
    output logic             wrap
);

    localparam int unsigned DCW = $clog2(DWELL + 1);

    logic [W-1:0]   chan [N];
    logic [SW-1:0]  cur;
    logic [DCW-1:0] dcnt;
    logic [SW-1:0]  nxt;
    logic [DCW-1:0] dcnt_nxt;
    logic           wrap_nxt;
    logic [SW-1:0]  adv;
    logic           adv_wrap;
    logic           any_en;
    logic           cur_en;
    logic           sel_en;

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = d[k*W +: W];
    end

`ifdef MUX_SCAN_MASK_EN
    assign any_en = |msk;
    assign cur_en = msk[cur];
    assign sel_en = msk[s];

    // Next enabled channel after cur in circular order; wraps when the index does not increase.
    always_comb begin
        logic        found;
        int unsigned idx;
        adv      = cur;
        adv_wrap = 1'b0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = 32'(cur) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && msk[SW'(idx)]) begin
                found    = 1'b1;
                adv      = SW'(idx);
                adv_wrap = (idx <= 32'(cur));
            end
        end
    end
`else
    assign any_en = 1'b1;
    assign cur_en = 1'b1;
    assign sel_en = 1'b1;

    always_comb begin
        adv      = cur + SW'(1);
        adv_wrap = 1'b0;
        if (cur == SW'(N - 1)) begin
            adv      = '0;
            adv_wrap = 1'b1;
        end
    end
`endif

    // Next channel / dwell count; current mode's rules always win over ld.
    always_comb begin
        nxt      = cur;
        dcnt_nxt = '0;
        wrap_nxt = 1'b0;
        if (any_en) begin
            if (!cur_en) begin
                nxt      = adv;
                wrap_nxt = mode & adv_wrap;
            end else if (mode) begin
                if (dcnt == DCW'(DWELL - 1)) begin
                    nxt      = adv;
                    wrap_nxt = adv_wrap;
                end else begin
                    dcnt_nxt = dcnt + DCW'(1);
                end
            end else if (ld && (32'(s) < N) && sel_en) begin
                nxt = s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= '0;
            dcnt <= '0;
            ch   <= '0;
            out  <= '0;
            vld  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            cur  <= nxt;
            dcnt <= dcnt_nxt;
            ch   <= nxt;
            out  <= any_en ? chan[nxt] : '0;
            vld  <= any_en;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed, table-driven bench for mux_scan; covers the mask feature when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan;

    logic clk;
    logic rst_n;

    // u8: W=8 N=8 DWELL=3
    logic [63:0] d8;
    logic [2:0]  s8;
    logic        ld8, mode8;
    logic [7:0]  out8;
    logic [2:0]  ch8;
    logic        vld8, wrap8;

    // u6: W=8 N=6 DWELL=3
    logic [47:0] d6;
    logic [2:0]  s6;
    logic        ld6, mode6;
    logic [7:0]  out6;
    logic [2:0]  ch6;
    logic        vld6, wrap6;

    // u1: W=8 N=8 DWELL=1
    logic [63:0] d1;
    logic [2:0]  s1;
    logic        ld1, mode1;
    logic [7:0]  out1;
    logic [2:0]  ch1;
    logic        vld1, wrap1;
    logic [7:0]  msk1;

    int unsigned n_cmp;
    int unsigned n_err;

    mux_scan #(.W(8), .N(8), .SW(3), .DWELL(3)) u8 (
        .clk(clk), .rst_n(rst_n), .d(d8), .s(s8), .ld(ld8), .mode(mode8),
`ifdef MUX_SCAN_MASK_EN
        .msk(8'hFF),
`endif
        .out(out8), .ch(ch8), .vld(vld8), .wrap(wrap8)
    );

    mux_scan #(.W(8), .N(6), .SW(3), .DWELL(3)) u6 (
        .clk(clk), .rst_n(rst_n), .d(d6), .s(s6), .ld(ld6), .mode(mode6),
`ifdef MUX_SCAN_MASK_EN
        .msk(6'h3F),
`endif
        .out(out6), .ch(ch6), .vld(vld6), .wrap(wrap6)
    );

    mux_scan #(.W(8), .N(8), .SW(3), .DWELL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .d(d1), .s(s1), .ld(ld1), .mode(mode1),
`ifdef MUX_SCAN_MASK_EN
        .msk(msk1),
`endif
        .out(out1), .ch(ch1), .vld(vld1), .wrap(wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string nm, input int unsigned c, input int unsigned o,
                        input int unsigned v, input int unsigned w);
        chk({nm, ".ch"},   32'(ch8),   c);
        chk({nm, ".out"},  32'(out8),  o);
        chk({nm, ".vld"},  32'(vld8),  v);
        chk({nm, ".wrap"}, 32'(wrap8), w);
    endtask

    typedef struct {
        logic       mode;
        logic       ld;
        logic [2:0] s;
        logic [2:0] ch;
        logic [7:0] out;
        logic       wrap;
    } vec_t;

    vec_t tbl [13];

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int k = 0; k < 8; k++) begin
            d8[k*8 +: 8] = 8'(8'h10 + k);
            d1[k*8 +: 8] = 8'(8'h30 + k);
        end
        for (int k = 0; k < 6; k++) begin
            d6[k*8 +: 8] = 8'(8'h20 + k);
        end
        s8 = '0; ld8 = 1'b0; mode8 = 1'b0;
        s6 = '0; ld6 = 1'b0; mode6 = 1'b0;
        s1 = '0; ld1 = 1'b0; mode1 = 1'b0;
        msk1 = 8'hFF;

        // mode, ld, s -> ch, out, wrap (vld always 1)
        tbl[0]  = '{1'b0, 1'b1, 3'd5, 3'd5, 8'h15, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'd2, 3'd5, 8'h15, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd2, 3'd2, 8'h12, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 3'd7, 3'd2, 8'h12, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd0, 3'd2, 8'h12, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 3'd3, 8'h13, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd0, 3'd3, 8'h13, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 3'd3, 8'h13, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'd7, 3'd7, 8'h17, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 3'd7, 8'h17, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 3'd7, 8'h17, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 1'b0};

        // Reset state, including across a clock edge while held
        rst_n = 1'b0;
        #2;
        chk8("reset", 0, 0, 0, 0);
        tick();
        chk8("reset_edge", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("pre_first_edge.vld", 32'(vld8), 0);

        for (int i = 0; i < 13; i++) begin
            mode8 = tbl[i].mode;
            ld8   = tbl[i].ld;
            s8    = tbl[i].s;
            tick();
            chk8($sformatf("vec%0d", i), 32'(tbl[i].ch), 32'(tbl[i].out), 1, 32'(tbl[i].wrap));
        end

        // Held channel tracks new data with one-cycle latency
        mode8 = 1'b0; ld8 = 1'b0;
        tick();
        d8[7:0] = 8'hAA;
        chk("data_latency.before", 32'(out8), 32'h10);
        tick();
        chk("data_latency.after", 32'(out8), 32'hAA);
        d8[7:0] = 8'h10;

        // Out-of-range select ignored on N=6
        ld6 = 1'b1; s6 = 3'd4;
        tick();
        chk("n6_load.ch", 32'(ch6), 4);
        chk("n6_load.out", 32'(out6), 32'h24);
        s6 = 3'd7;
        tick();
        chk("n6_s7.ch", 32'(ch6), 4);
        chk("n6_s7.out", 32'(out6), 32'h24);
        s6 = 3'd6;
        tick();
        chk("n6_s6.ch", 32'(ch6), 4);
        ld6 = 1'b0;

        // DWELL=1 advances every cycle
        mode1 = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("dw1_%0d.ch", e), 32'(ch1), 32'(e % 8));
            chk($sformatf("dw1_%0d.out", e), 32'(out1), 32'(8'h30 + (e % 8)));
            chk($sformatf("dw1_%0d.wrap", e), 32'(wrap1), (e % 8 == 0) ? 1 : 0);
        end
`ifdef MUX_SCAN_MASK_EN
        msk1 = 8'b1010_0010;
        tick();
        chk("msk.ch5", 32'(ch1), 5);
        chk("msk.ch5.wrap", 32'(wrap1), 0);
        tick();
        chk("msk.ch7", 32'(ch1), 7);
        tick();
        chk("msk.ch1", 32'(ch1), 1);
        chk("msk.ch1.wrap", 32'(wrap1), 1);
        tick();
        chk("msk.ch5b", 32'(ch1), 5);
        chk("msk.ch5b.wrap", 32'(wrap1), 0);
        msk1 = 8'h00;
        tick();
        chk("msk0.out", 32'(out1), 0);
        chk("msk0.vld", 32'(vld1), 0);
        chk("msk0.ch", 32'(ch1), 5);
        msk1 = 8'hFF;
`endif
        mode1 = 1'b0;

        // Full scan with DWELL=3 from a fresh reset
        mode8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk8("scan_start", 0, 0, 0, 0);
        for (int e = 1; e <= 28; e++) begin
            tick();
            chk8($sformatf("scan%0d", e), 32'((e / 3) % 8), 32'(8'h10 + (e / 3) % 8), 1,
                 ((e % 3 == 0) && ((e / 3) % 8 == 0)) ? 1 : 0);
        end

        // Async reset between edges mid-scan
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart from channel 0, then mode change mid-dwell at ch=4, dcnt=1
        for (int e = 1; e <= 13; e++) begin
            tick();
            chk($sformatf("restart%0d.ch", e), 32'(ch8), 32'((e / 3) % 8));
        end
        mode8 = 1'b0;
        tick();
        chk("freeze1.ch", 32'(ch8), 4);
        tick();
        chk("freeze2.ch", 32'(ch8), 4);
        mode8 = 1'b1; ld8 = 1'b1; s8 = 3'd2;
        #1;
        chk("resume0.ch", 32'(ch8), 4);
        tick();
        chk("resume1.ch", 32'(ch8), 4);
        ld8 = 1'b0;
        tick();
        chk("resume2.ch", 32'(ch8), 4);
        tick();
        chk("resume3.ch", 32'(ch8), 5);
        chk("resume3.out", 32'(out8), 32'h15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter W, default 1: data bits per channel, W >= 1.
REQ-002 Parameter N, default 8: channel count, 2 <= N <= 256.
REQ-003 Parameter SW, default 3: select width, SW = ceil(log2(N)).
REQ-004 Parameter DWELL, default 4: cycles per channel in scan mode, 1 <= DWELL <= 65535.
REQ-005 Port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port d, input, N*W: channel data; channel k occupies bits [k*W +: W].
REQ-008 Port s, input, SW: manual channel select.
REQ-009 Port ld, input, 1: load s into the channel register in manual mode.
REQ-010 Port mode, input, 1: 0 = manual, 1 = scan.
REQ-011 Port out, output, W: registered data of the selected channel.
REQ-012 Port ch, output, SW: index of the channel currently presented on out.
REQ-013 Port vld, output, 1: out holds valid data for channel ch.
REQ-014 Port wrap, output, 1: one-cycle pulse when scan advances from the last channel to channel 0.

Function
REQ-015 The block SHALL keep a channel register cur and a dwell counter dcnt (width ceil(log2(DWELL+1))).
REQ-016 Each edge SHALL compute nxt (the next value of cur), then register cur <= nxt, ch <= nxt, and out <= d[nxt*W +: W]; latency from d to out is one cycle.
REQ-017 Manual mode: nxt = s when ld=1 and s < N, otherwise nxt = cur; ld with s >= N SHALL be ignored; dcnt is held at 0.
REQ-018 Scan mode: ld and s SHALL be ignored; dcnt increments each cycle; when dcnt = DWELL-1, dcnt <= 0 and nxt = cur+1, with N-1 wrapping to 0.
REQ-019 wrap SHALL be 1 for exactly the cycle after the edge on which cur moves from N-1 to 0 in scan mode, and 0 otherwise.
REQ-020 A mode 0->1 change SHALL clear dcnt and start scanning from the current cur. A mode 1->0 change SHALL freeze cur at its current value.
REQ-021 If ld=1 and mode changes on the same edge, mode takes priority: the new mode's rules apply to that edge.
REQ-022 vld SHALL be 0 from reset until the first rising edge after rst_n deasserts, and 1 thereafter, except where REQ-026 applies.
REQ-023 With DWELL=1, the channel SHALL advance every cycle in scan mode.

Reset
REQ-024 While rst_n=0, regardless of clk: out=0, ch=0, cur=0, dcnt=0, vld=0, wrap=0.
REQ-025 Reset asserted mid-scan SHALL abort the scan; after release, scanning (if mode=1) SHALL restart at channel 0 with dcnt=0.

Configuration
REQ-026 Macro MUX_SCAN_MASK_EN defined adds port msk (input, N bits; 1 = channel enabled) and applies these rules:
- Scan advances to the next enabled channel in circular order.
- wrap pulses when the advance passes through index N-1 to a lower index.
- A manual load of a disabled channel is ignored.
- If cur becomes disabled, the next edge moves it to the next enabled channel.
- If msk is all-zero: cur holds, out=0, and vld=0.
REQ-027 Macro MUX_SCAN_MASK_EN undefined: no msk port, all N channels are enabled, and behaviour is exactly REQ-015..REQ-025.

Verification
REQ-028 Reset and manual load: W=8, N=8, d[k]=0x10+k, mode=0, ld=1, s=5 -> one cycle later out=0x15, ch=5, vld=1.
REQ-029 Invalid select: N=6, s=7, ld=1 -> ch and out unchanged.
REQ-030 Scan with DWELL=3: ch sequence 0,0,0,1,1,1,...,7,7,7,0; wrap=1 for the single cycle where ch becomes 0.
REQ-031 Mode change mid-dwell: switch to manual at ch=4 with dcnt=1 -> ch stays 4; return to scan -> 4 held for exactly 3 cycles, then 5.
REQ-032 Async reset: assert rst_n=0 between clock edges during scan -> out, ch, vld, and wrap are 0 immediately; after release, scan restarts at channel 0.
REQ-033 MUX_SCAN_MASK_EN: msk=8'b1010_0010, DWELL=1 -> ch sequence 1,5,7,1 with wrap on the 7->1 step; msk=0 -> out=0 and vld=0.
